// File: rtl/diff_deframe_if.sv
// Bit-stream in / byte-stream out bundle between the demod slicer, the deframer and the UART TX path.
// header_inverted only exists when DEFRAME_POLARITY_AUTO_EN is defined.
interface diff_deframe_if #(
    parameter int unsigned UART_DATA_WIDTH = 8
);
    logic                       demod_bit;
    logic                       demod_valid;
    logic [UART_DATA_WIDTH-1:0] deframe_uart_data;
    logic                       deframe_uart_valid;
    logic                       uart_deframe_ready;
    logic                       frame_lock;
    logic                       frame_done;
    logic                       byte_overflow;
`ifdef DEFRAME_POLARITY_AUTO_EN
    logic                       header_inverted;

    modport master (
        input  demod_bit, demod_valid, uart_deframe_ready,
        output deframe_uart_data, deframe_uart_valid, frame_lock, frame_done, byte_overflow,
               header_inverted
    );
    modport slave (
        output demod_bit, demod_valid, uart_deframe_ready,
        input  deframe_uart_data, deframe_uart_valid, frame_lock, frame_done, byte_overflow,
               header_inverted
    );
`else
    modport master (
        input  demod_bit, demod_valid, uart_deframe_ready,
        output deframe_uart_data, deframe_uart_valid, frame_lock, frame_done, byte_overflow
    );
    modport slave (
        output demod_bit, demod_valid, uart_deframe_ready,
        input  deframe_uart_data, deframe_uart_valid, frame_lock, frame_done, byte_overflow
    );
`endif
endinterface

// File: rtl/diff_deframe.sv
// Purpose: find the differentially encoded frame header, diff-decode the payload, pack LSB-first bytes.
// Latency: a byte is valid the cycle after its last bit's valid cycle.
// Backpressure: single output register; an unaccepted byte is overwritten and byte_overflow sticks.
// DEFRAME_POLARITY_AUTO_EN: also lock on the inverted header and report it on header_inverted.
module diff_deframe #(
    parameter int unsigned               FRAME_HEAD_LEN  = 16,
    parameter logic [FRAME_HEAD_LEN-1:0] FRAME_HEAD      = 16'hEB90,
    parameter int unsigned               FRAME_DATA_LEN  = 64,
    parameter int unsigned               UART_DATA_WIDTH = 8
) (
    input logic            sys_clk,
    input logic            rst,
    diff_deframe_if.master bus
);
    typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

    localparam int unsigned BCW = (UART_DATA_WIDTH > 1) ? $clog2(UART_DATA_WIDTH) : 1;
    localparam logic [15:0]    LAST_BIT      = 16'(FRAME_DATA_LEN - 1);
    localparam logic [BCW-1:0] LAST_BYTE_BIT = BCW'(UART_DATA_WIDTH - 1);

    // Header as the encoder puts it on the wire, starting from reference bit 1.
    function automatic logic [FRAME_HEAD_LEN-1:0] enc_head_f();
        logic [FRAME_HEAD_LEN-1:0] e;
        logic                      r;
        r = 1'b1;
        e = '0;
        for (int i = 0; i < int'(FRAME_HEAD_LEN); i++) begin
            r    = r ^ FRAME_HEAD[i];
            e[i] = r;
        end
        return e;
    endfunction

    localparam logic [FRAME_HEAD_LEN-1:0] ENC_HEAD = enc_head_f();

    state_t                      state_q, state_d;
    logic [FRAME_HEAD_LEN-1:0]   window_q, window_d;
    logic                        prev_raw_q, prev_raw_d;
    logic [15:0]                 bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]              bcnt_q, bcnt_d;
    logic [UART_DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [UART_DATA_WIDTH-1:0]  out_dat_q, out_dat_d;
    logic                        out_vld_q, out_vld_d;
    logic                        lock_q, lock_d;
    logic                        done_q, done_d;
    logic                        ovf_q, ovf_d;
`ifdef DEFRAME_POLARITY_AUTO_EN
    logic                        inv_q, inv_d;
`endif

    logic [FRAME_HEAD_LEN-1:0]   window_sh;
    logic                        decoded;
    logic [UART_DATA_WIDTH-1:0]  byte_new;
    logic                        head_hit;

    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        prev_raw_d = prev_raw_q;
        bit_cnt_d  = bit_cnt_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        out_dat_d  = out_dat_q;
        out_vld_d  = out_vld_q;
        lock_d     = lock_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
`ifdef DEFRAME_POLARITY_AUTO_EN
        inv_d      = inv_q;
`endif
        window_sh = {bus.demod_bit, window_q[FRAME_HEAD_LEN-1:1]};
        decoded   = bus.demod_bit ^ prev_raw_q;
        byte_new  = {decoded, shreg_q[UART_DATA_WIDTH-1:1]};
        head_hit  = 1'b0;

        if (out_vld_q && bus.uart_deframe_ready) begin
            out_vld_d = 1'b0;
        end

        if (bus.demod_valid) begin
            case (state_q)
                HUNT: begin
                    window_d = window_sh;
                    if (window_sh == ENC_HEAD) begin
                        head_hit = 1'b1;
`ifdef DEFRAME_POLARITY_AUTO_EN
                        inv_d    = 1'b0;
                    end else if (window_sh == ~ENC_HEAD) begin
                        head_hit = 1'b1;
                        inv_d    = 1'b1;
`endif
                    end
                    if (head_hit) begin
                        state_d    = DATA;
                        prev_raw_d = bus.demod_bit;
                        bit_cnt_d  = '0;
                        bcnt_d     = '0;
                        lock_d     = 1'b1;
                    end
                end
                DATA: begin
                    prev_raw_d = bus.demod_bit;
                    shreg_d    = byte_new;
                    bit_cnt_d  = bit_cnt_q + 16'd1;
                    bcnt_d     = bcnt_q + 1'b1;
                    if (bcnt_q == LAST_BYTE_BIT) begin
                        bcnt_d    = '0;
                        out_dat_d = byte_new;
                        out_vld_d = 1'b1;
                        // Same-cycle accept frees the register, so only a held byte counts as lost.
                        if (out_vld_q && !bus.uart_deframe_ready) begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = HUNT;
                        window_d   = '0;
                        prev_raw_d = 1'b1;
                        bit_cnt_d  = '0;
                        lock_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= HUNT;
            window_q   <= '0;
            prev_raw_q <= 1'b1;
            bit_cnt_q  <= '0;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            out_dat_q  <= '0;
            out_vld_q  <= 1'b0;
            lock_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef DEFRAME_POLARITY_AUTO_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            prev_raw_q <= prev_raw_d;
            bit_cnt_q  <= bit_cnt_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
            out_dat_q  <= out_dat_d;
            out_vld_q  <= out_vld_d;
            lock_q     <= lock_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
`ifdef DEFRAME_POLARITY_AUTO_EN
            inv_q      <= inv_d;
`endif
        end
    end

    assign bus.deframe_uart_data  = out_dat_q;
    assign bus.deframe_uart_valid = out_vld_q;
    assign bus.frame_lock         = lock_q;
    assign bus.frame_done         = done_q;
    assign bus.byte_overflow      = ovf_q;
`ifdef DEFRAME_POLARITY_AUTO_EN
    assign bus.header_inverted    = inv_q;
`endif
endmodule
